// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit.
// Drives the data bus (req/gnt, rvalid), steers store lanes, formats load
// data for the M/W register, and stalls the pipe while an access is in flight.
module mem_stage_lsu #(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_m,
  input  logic        MemRead_m,
  input  logic        MemWrite_m,
  input  logic [2:0]  funct3_m,
  input  logic [31:0] ALUResult_m,
  input  logic [31:0] WriteData_m,
  output logic [31:0] ReadData_m,
  output logic        stall_m,
  output logic        bubble_w,
  output logic        misalign_m,
  output logic        fault_m,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  // Last counter value before the timeout fires; unused when TIMEOUT is 0.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t           r_state;
  logic [2:0]       r_f3;
  logic [1:0]       r_a;
  logic             r_st;
  logic [31:0]      r_rdata;
  logic [CNT_W-1:0] r_cnt;

  logic        w_acc, w_st, w_illegal, w_mis, w_go, w_tmo, w_tmo_fire;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_fmt;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // rst_n gates the access so every output reads 0 while reset is held,
  // even if upstream still presents a valid instruction.
  assign w_acc = rst_n & valid_m & (MemRead_m | MemWrite_m);
  assign w_st  = MemWrite_m;  // read+write together is a store

  // Size/sign legality and alignment, judged only on the first (IDLE) cycle.
  always_comb begin
    w_illegal = 1'b0;
    if (w_st) w_illegal = funct3_m[2] | (funct3_m[1:0] == 2'b11);
    else      w_illegal = (funct3_m == 3'b011) | (funct3_m[2:1] == 2'b11);
    w_mis = ~w_illegal &
            (((funct3_m[1:0] == 2'b01) & ALUResult_m[0]) |
             ((funct3_m[1:0] == 2'b10) & (ALUResult_m[1:0] != 2'b00)));
  end

  assign w_go  = (r_state == S_IDLE) & w_acc & ~w_illegal & ~w_mis;
  assign w_tmo = (TIMEOUT != 0) & ((r_state == S_REQ) | (r_state == S_WAIT)) &
                 (r_cnt == TMO_LAST);
  // A response arriving on the last allowed WAIT cycle still wins.
  assign w_tmo_fire = w_tmo & ~((r_state == S_WAIT) & mem_rvalid);

  assign mem_req    = w_go | ((r_state == S_REQ) & ~w_tmo);
  assign stall_m    = w_go | (r_state == S_REQ) | (r_state == S_WAIT);
  assign bubble_w   = stall_m;
  assign misalign_m = (r_state == S_IDLE) & w_acc & w_mis;
  assign fault_m    = ((r_state == S_IDLE) & w_acc & w_illegal) | w_tmo_fire;
  assign ReadData_m = (r_state == S_DONE) ? r_rdata : 32'h0;

  // Store lane steering from the M-stage inputs, which upstream holds
  // stable for the whole stall.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = 32'h0;
    if (w_st) begin
      case (funct3_m[1:0])
        2'b00:   begin w_be = 4'b0001 << ALUResult_m[1:0]; w_wdata = {4{WriteData_m[7:0]}};  end
        2'b01:   begin w_be = 4'b0011 << ALUResult_m[1:0]; w_wdata = {2{WriteData_m[15:0]}}; end
        default: begin w_be = 4'b1111;                     w_wdata = WriteData_m;            end
      endcase
    end
  end

  assign mem_we    = mem_req & w_st;
  assign mem_addr  = mem_req ? {ALUResult_m[31:2], 2'b00} : 32'h0;
  assign mem_be    = mem_req ? w_be : 4'b0000;
  assign mem_wdata = mem_req ? w_wdata : 32'h0;

  // Load extraction and extension, using the captured size and offset.
  always_comb begin
    w_byte = mem_rdata[{r_a, 3'b000} +: 8];
    w_half = r_a[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_f3)
      3'b000:  w_fmt = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_fmt = {{16{w_half[15]}}, w_half};
      3'b100:  w_fmt = {24'h0, w_byte};
      3'b101:  w_fmt = {16'h0, w_half};
      default: w_fmt = mem_rdata;
    endcase
  end

  // Access FSM: capture on issue, wait for grant / response, one DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_f3    <= 3'b000;
      r_a     <= 2'b00;
      r_st    <= 1'b0;
      r_rdata <= 32'h0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_go) begin
            r_f3    <= funct3_m;
            r_a     <= ALUResult_m[1:0];
            r_st    <= w_st;
            r_rdata <= 32'h0;
            r_cnt   <= '0;
            if (mem_gnt) r_state <= w_st ? S_DONE : S_WAIT;
            else         r_state <= S_REQ;
          end
        end
        S_REQ: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_tmo)        r_state <= S_DONE;
          else if (mem_gnt) r_state <= r_st ? S_DONE : S_WAIT;
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (mem_rvalid) begin
            r_rdata <= w_fmt;
            r_state <= S_DONE;
          end else if (w_tmo) begin
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: a table of single accesses with
// hand-computed results, plus a reset-during-WAIT sequence.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_m, MemRead_m, MemWrite_m;
  logic [2:0]  funct3_m;
  logic [31:0] ALUResult_m, WriteData_m;
  logic [31:0] ReadData_m;
  logic        stall_m, bubble_w, misalign_m, fault_m;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  int nchk = 0;
  int nerr = 0;

  mem_stage_lsu #(.TIMEOUT(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .valid_m(valid_m), .MemRead_m(MemRead_m),
    .MemWrite_m(MemWrite_m), .funct3_m(funct3_m), .ALUResult_m(ALUResult_m),
    .WriteData_m(WriteData_m), .ReadData_m(ReadData_m), .stall_m(stall_m),
    .bubble_w(bubble_w), .misalign_m(misalign_m), .fault_m(fault_m),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr, wd, rdata;
    int          gdly, rdly;
    int          e_nreq, e_stall;
    logic        e_mis, e_flt, e_we;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_wdata, e_rd;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic add(input string nm, input logic rd, input logic wr, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdata,
                     input int gdly, input int rdly, input int e_nreq, input int e_stall,
                     input logic e_mis, input logic e_flt, input logic e_we, input logic [3:0] e_be,
                     input logic [31:0] e_addr, input logic [31:0] e_wdata, input logic [31:0] e_rd);
    vec_t v;
    v.name = nm; v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wd = wd; v.rdata = rdata;
    v.gdly = gdly; v.rdly = rdly; v.e_nreq = e_nreq; v.e_stall = e_stall;
    v.e_mis = e_mis; v.e_flt = e_flt; v.e_we = e_we; v.e_be = e_be;
    v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_rd = e_rd;
    vecs.push_back(v);
  endtask

  // Runs one access starting just after a rising edge; the memory model
  // grants after gdly request cycles and answers rdly cycles after grant.
  task automatic run(input vec_t v);
    int nreq = 0, nstall = 0, k = -1;
    logic mis = 1'b0, flt = 1'b0, bus_bad = 1'b0, bw_bad = 1'b0, done = 1'b0;
    logic [31:0] rd = 32'h0;
    valid_m = 1'b1; MemRead_m = v.rd; MemWrite_m = v.wr; funct3_m = v.f3;
    ALUResult_m = v.addr; WriteData_m = v.wd;
    for (int c = 0; c < 40 && !done; c++) begin
      if (k >= 0) k++;
      mem_rvalid = (k >= 1) && (k == v.rdly);
      mem_rdata  = mem_rvalid ? v.rdata : 32'h5A5A5A5A;
      #1;
      mis |= misalign_m;
      flt |= fault_m;
      if (mem_req) begin
        nreq++;
        if (mem_we !== v.e_we || mem_be !== v.e_be || mem_addr !== v.e_addr) bus_bad = 1'b1;
        if (v.wr && mem_wdata !== v.e_wdata) bus_bad = 1'b1;
        mem_gnt = (nreq > v.gdly);
        if (mem_gnt && !v.wr) k = 0;
      end
      #1;
      if (bubble_w !== stall_m) bw_bad = 1'b1;
      if (stall_m) nstall++;
      else begin done = 1'b1; rd = ReadData_m; end
      @(posedge clk); #1;
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
    end
    valid_m = 1'b0; MemRead_m = 1'b0; MemWrite_m = 1'b0;
    chk({v.name, " done"},     32'(done),    32'h1);
    chk({v.name, " stall"},    32'(nstall),  32'(v.e_stall));
    chk({v.name, " nreq"},     32'(nreq),    32'(v.e_nreq));
    chk({v.name, " misalign"}, 32'(mis),     32'(v.e_mis));
    chk({v.name, " fault"},    32'(flt),     32'(v.e_flt));
    chk({v.name, " rdata"},    rd,           v.e_rd);
    chk({v.name, " bubble"},   32'(bw_bad),  32'h0);
    if (v.e_nreq > 0) chk({v.name, " bus"}, 32'(bus_bad), 32'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    // name rd wr f3 addr wd rdata gdly rdly | nreq stall mis flt we be addr wdata rd
    add("LW",      1,0,3'b010,32'h100,0,32'hDEADBEEF,0,1, 1,2,0,0,0,4'hF,32'h100,0,32'hDEADBEEF);
    add("LB103",   1,0,3'b000,32'h103,0,32'h80112233,0,1, 1,2,0,0,0,4'hF,32'h100,0,32'hFFFFFF80);
    add("LBU103",  1,0,3'b100,32'h103,0,32'h80112233,0,1, 1,2,0,0,0,4'hF,32'h100,0,32'h00000080);
    add("LHU102",  1,0,3'b101,32'h102,0,32'h80112233,0,1, 1,2,0,0,0,4'hF,32'h100,0,32'h00008011);
    add("LH102",   1,0,3'b001,32'h102,0,32'h80112233,0,1, 1,2,0,0,0,4'hF,32'h100,0,32'hFFFF8011);
    add("LB101",   1,0,3'b000,32'h101,0,32'h80112233,0,1, 1,2,0,0,0,4'hF,32'h100,0,32'h00000022);
    add("LWg1r2",  1,0,3'b010,32'h104,0,32'h12345678,1,2, 2,4,0,0,0,4'hF,32'h104,0,32'h12345678);
    add("LWr3",    1,0,3'b010,32'h108,0,32'hA0B0C0D0,0,3, 1,4,0,0,0,4'hF,32'h108,0,32'hA0B0C0D0);
    add("SB201",   0,1,3'b000,32'h201,32'h000000A5,0,3,0, 4,4,0,0,1,4'b0010,32'h200,32'hA5A5A5A5,0);
    add("SH202",   0,1,3'b001,32'h202,32'h1234BEEF,0,0,0, 1,1,0,0,1,4'b1100,32'h200,32'hBEEFBEEF,0);
    add("SW30C",   0,1,3'b010,32'h30C,32'hCAFEF00D,0,1,0, 2,2,0,0,1,4'b1111,32'h30C,32'hCAFEF00D,0);
    add("RWasSB",  1,1,3'b000,32'h003,32'h00000077,0,0,0, 1,1,0,0,1,4'b1000,32'h000,32'h77777777,0);
    add("LWmis",   1,0,3'b010,32'h102,0,32'h11111111,0,1, 0,0,1,0,0,4'h0,0,0,0);
    add("LHmis",   1,0,3'b001,32'h101,0,32'h11111111,0,1, 0,0,1,0,0,4'h0,0,0,0);
    add("SHmis",   0,1,3'b001,32'h203,32'h1,0,0,0,       0,0,1,0,0,4'h0,0,0,0);
    add("L011",    1,0,3'b011,32'h100,0,32'h11111111,0,1, 0,0,0,1,0,4'h0,0,0,0);
    add("S100",    0,1,3'b100,32'h100,32'h1,0,0,0,       0,0,0,1,0,4'h0,0,0,0);
    add("L110mis", 1,0,3'b110,32'h102,0,32'h11111111,0,1, 0,0,0,1,0,4'h0,0,0,0);
    add("LWtmo",   1,0,3'b010,32'h100,0,32'h99999999,99,1, 4,5,0,1,0,4'hF,32'h100,0,0);
    add("SB000",   0,1,3'b000,32'h000,32'h00000001,0,0,0, 1,1,0,0,1,4'b0001,32'h000,32'h01010101,0);

    // Reset with a legal load presented: everything must read 0.
    rst_n = 1'b0; valid_m = 1'b1; MemRead_m = 1'b1; MemWrite_m = 1'b0; funct3_m = 3'b010;
    ALUResult_m = 32'h100; WriteData_m = 32'h0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    #12;
    chk("rst mem_req",  32'(mem_req),  32'h0);
    chk("rst stall",    32'(stall_m),  32'h0);
    chk("rst mem_be",   32'(mem_be),   32'h0);
    chk("rst rdata",    ReadData_m,    32'h0);
    valid_m = 1'b0; MemRead_m = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) run(vecs[i]);

    // Reset while waiting for a read response.
    valid_m = 1'b1; MemRead_m = 1'b1; funct3_m = 3'b010; ALUResult_m = 32'h100;
    #1; mem_gnt = 1'b1;
    @(posedge clk); #1; mem_gnt = 1'b0;
    #1;
    chk("wait stall",   32'(stall_m), 32'h1);
    chk("wait mem_req", 32'(mem_req), 32'h0);
    rst_n = 1'b0; #1;
    chk("mid-rst mem_req", 32'(mem_req), 32'h0);
    chk("mid-rst stall",   32'(stall_m), 32'h0);
    chk("mid-rst rdata",   ReadData_m,   32'h0);
    chk("mid-rst fault",   32'(fault_m), 32'h0);
    @(posedge clk); #1; rst_n = 1'b1; valid_m = 1'b0; MemRead_m = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFFFFFF; #1;
    chk("stray stall", 32'(stall_m), 32'h0);
    @(posedge clk); #1; mem_rvalid = 1'b0; #1;
    chk("stray rdata", ReadData_m,   32'h0);
    chk("stray stall2", 32'(stall_m), 32'h0);
    @(posedge clk); #1;
    run(vecs[0]);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Load/store unit of the memory stage in the pipelined RV32I core. It produces the write-back-bound load data (ReadData_m) for the M/W pipeline register and drives that register's hold and bubble controls.
- Talks to data memory over a request/grant plus response-valid bus. Handles byte and halfword lane steering, load sign/zero extension, misalignment detection and bus timeout.
- Stalls the pipeline for multi-cycle accesses.

Parameters:
- TIMEOUT, 256, cycles allowed in REQ+WAIT before a fault is raised; 0 disables the timeout.
- CNT_W, 9, width of the timeout counter; must satisfy 2**CNT_W > TIMEOUT.

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- valid_m  input  1  M-stage slot holds a real instruction
- MemRead_m  input  1  load in M stage
- MemWrite_m  input  1  store in M stage
- funct3_m  input  3  access size/sign
- ALUResult_m  input  32  effective address
- WriteData_m  input  32  store data (rs2)
- ReadData_m  output  32  formatted load data to the M/W register
- stall_m  output  1  hold F/D/E/M registers
- bubble_w  output  1  clear request for the M/W register; equals stall_m
- misalign_m  output  1  one-cycle misaligned-access pulse
- fault_m  output  1  one-cycle pulse on illegal funct3 or timeout
- mem_req  output  1  bus request
- mem_we  output  1  1 = write
- mem_addr  output  32  word address; bits [1:0] are always 0
- mem_be  output  4  byte enables
- mem_wdata  output  32  lane-steered write data
- mem_gnt  input  1  request accepted this cycle
- mem_rvalid  input  1  read response valid
- mem_rdata  input  32  read response word

Behaviour:
Access definition
- access = valid_m & (MemRead_m | MemWrite_m).
- Both MemRead_m and MemWrite_m set: treated as a store.

Reset
- Asynchronous; state returns to IDLE. All outputs drive 0: ReadData_m=0, stall_m=0, mem_req=0, mem_be=0.
- Reset mid-access abandons the transaction. mem_rvalid is ignored outside WAIT.

Checks, evaluated in IDLE on funct3_m and ALUResult_m[1:0]
- Illegal: loads 011/110/111; stores other than 000/001/010.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
- Misaligned or illegal: no bus request, no stall. Raise misalign_m or fault_m for that cycle, ReadData_m=0, instruction advances.

FSM
- IDLE
  - Legal access: mem_req=1 combinationally, stall_m=1. Capture funct3, addr[1:0] and store flag.
  - mem_gnt=1 the same cycle: go to DONE for a store, WAIT for a load; otherwise go to REQ.
  - No access: stall_m=0, ReadData_m=0.
- REQ: hold mem_req and all bus outputs stable until mem_gnt. Then go to DONE for a store, WAIT for a load. stall_m=1.
- WAIT: mem_req=0, stall_m=1. On mem_rvalid, register the formatted mem_rdata and go to DONE.
- DONE: stall_m=0. ReadData_m = registered data (0 for a store). Instruction advances at this clock edge; next state is IDLE.
- Minimum stall: store 1 cycle; load 2 cycles (gnt in cycle 0, rvalid in cycle 1).
- Upstream holds M-stage inputs stable while stall_m=1.

Lane steering
- mem_addr = {addr[31:2],2'b00}.
- SB: be = 0001<<addr[1:0], wdata = byte replicated ×4.
- SH: be = 0011<<addr[1:0], wdata = half replicated ×2.
- SW: be = 1111, wdata unchanged.
- Loads: be = 1111.

Load format, using captured addr[1:0]
- LB/LBU select byte addr[1:0]; LH/LHU select half addr[1]; LW passes the word.
- LB/LH sign-extend; LBU/LHU zero-extend.

Timeout
- Counter cleared on entry to REQ. Increments each cycle in REQ/WAIT.
- When it reaches TIMEOUT: pulse fault_m, drop mem_req, go to DONE with ReadData_m=0.
- Late responses after a timeout are out of scope; the system resets the bus.

Test Plan:
- LW addr 0x100, gnt same cycle, rvalid next cycle with 0xDEADBEEF -> stall_m high exactly 2 cycles, mem_be=1111, ReadData_m=0xDEADBEEF in DONE.
- LB addr 0x103, rdata 0x80112233 -> ReadData_m=0xFFFFFF80. LBU same access -> 0x00000080. LHU addr 0x102 -> 0x00008011.
- SB addr 0x201, WriteData 0x000000A5, gnt delayed 3 cycles -> mem_req/addr/be stable for 4 cycles, mem_addr=0x200, mem_be=0010, mem_wdata=0xA5A5A5A5, stall_m high 4 cycles, mem_we=1.
- LW addr 0x102 -> misalign_m pulse 1 cycle, mem_req never asserted, stall_m=0, ReadData_m=0. Load funct3=011 -> fault_m pulse instead.
- TIMEOUT=4, load with mem_gnt held low -> fault_m at 4th REQ cycle, mem_req drops, DONE next with ReadData_m=0, then IDLE.
- rst_n asserted while in WAIT -> mem_req=0, stall_m=0, outputs 0 immediately. After release, a stray mem_rvalid is ignored and the next LW completes normally.
